ahb_mem_slave: RTL and testbench

AHB-Lite responder with byte-addressed backing memory; the synthesizable counterpart to the DMA controller's master port, serving as source or destination memory for DMA transfers. It accepts pipelined address/data phases, inserts a programmable number of wait states, applies byte-lane write strobes and returns a two-cycle ERROR response for illegal accesses. A memory array named `mem` (byte-wide, index = byte offset) stays directly in this module so benches can backdoor-load and inspect it.

---
 rtl/ahb_slave_pkg.sv | 25 ++
 rtl/ahb_slave_wait_ctr.sv | 27 ++
 rtl/ahb_mem_slave.sv | 177 +++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_pkg.sv
// Shared AHB-Lite responder definitions: transfer/response/size codes and FSM states.
// Error checking is compiled in only when AHB_SLAVE_ERR_EN is defined.
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

endpackage

// File: rtl/ahb_slave_wait_ctr.sv
// Wait-state down-counter: load on accept, decrement while stalled, flag zero.
module ahb_slave_wait_ctr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder with programmable wait states and byte strobes.
// Define AHB_SLAVE_ERR_EN to enable illegal-access detection and ERROR responses.
module ahb_mem_slave
    import ahb_slave_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADYIN,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  WSTRB,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int unsigned LOAD_VAL = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] off_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic          err_q;

    logic [7:0]    mem [MEM_DEPTH];

    logic          active;
    logic          can_accept;
    logic          accept;
    logic          err_d;
    logic          ctr_load;
    logic          ctr_dec;
    logic          ctr_zero;
    logic [AW-1:0] base;
    logic [1:0]    resp_d;

    always_comb begin
        active = 1'b0;
        unique case (HTRANS)
            HTRANS_IDLE:   active = 1'b0;
            HTRANS_BUSY:   active = 1'b0;
            HTRANS_NONSEQ: active = 1'b1;
            HTRANS_SEQ:    active = 1'b1;
        endcase
    end

    // Only a completing (or absent) data phase may overlap a new address phase
    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign accept     = HSEL && active && HREADYIN && can_accept;

`ifdef AHB_SLAVE_ERR_EN
    always_comb begin
        err_d = 1'b0;
        if ({1'b0, HADDR[11:0]} >= 13'(MEM_DEPTH)) begin
            err_d = 1'b1;
        end
        unique case (HSIZE)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (HADDR[0]) err_d = 1'b1;
            HSIZE_WORD: if (HADDR[1:0] != 2'b00) err_d = 1'b1;
            default:    err_d = 1'b1;
        endcase
    end
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q   <= HADDR[AW-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
                err_q   <= err_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (ctr_zero) state_d = S_DATA;
                else          ctr_dec = 1'b1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (err_d) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d  = S_WAIT;
                        ctr_load = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    ahb_slave_wait_ctr #(
        .WIDTH(CW)
    ) u_wait_ctr (
        .clk     (HCLK),
        .rst_n   (HRESET),
        .load    (ctr_load),
        .load_val(CW'(LOAD_VAL)),
        .dec     (ctr_dec),
        .zero    (ctr_zero)
    );

    assign base = {off_q[AW-1:2], 2'b00};

    // No reset on the array: contents survive reset for backdoor use
    always_ff @(posedge HCLK) begin
        if ((state_q == S_DATA) && write_q) begin
            for (int j = 0; j < 4; j++) begin
                if (WSTRB[j]) begin
                    mem[base + AW'(j)] <= HWDATA[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        resp_d    = HRESP_OKAY;
        HRDATA    = 32'h0;
        unique case (state_q)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: begin
                if (!write_q) begin
                    HRDATA = {mem[base + AW'(3)], mem[base + AW'(2)],
                              mem[base + AW'(1)], mem[base]};
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                resp_d    = HRESP_ERROR;
            end
            S_ERR2: resp_d = HRESP_ERROR;
            default: ;
        endcase
    end

`ifdef AHB_SLAVE_ERR_EN
    assign HRESP = resp_d;
    logic unused_bits;
    assign unused_bits = ^{HADDR, HTRANS, size_q, err_q, off_q[1:0]};
`else
    assign HRESP = HRESP_OKAY;
    logic unused_bits;
    assign unused_bits = ^{HADDR, HTRANS, size_q, err_q, off_q[1:0], resp_d};
`endif

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: zero-wait and three-wait instances on one bus.
// Error-path expectations follow whether AHB_SLAVE_ERR_EN is defined.
module tb_ahb_mem_slave;
    import ahb_slave_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        hsel0, hsel3, hwrite, on3, hreadyin;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  wstrb;
    logic [31:0] rd0, rd3;
    logic        ro0, ro3;
    logic [1:0]  rs0, rs3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    assign hreadyin = on3 ? ro3 : ro0;

    ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin),
        .HWDATA(hwdata), .WSTRB(wstrb), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(hreadyin),
        .HWDATA(hwdata), .WSTRB(wstrb), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; haddr = '0; hwdata = '0; wstrb = '0;
    endtask

    function automatic logic [31:0] mw0(input int a);
        return {dut0.mem[a+3], dut0.mem[a+2], dut0.mem[a+1], dut0.mem[a]};
    endfunction

    function automatic logic [31:0] mw3(input int a);
        return {dut3.mem[a+3], dut3.mem[a+2], dut3.mem[a+1], dut3.mem[a]};
    endfunction

    // Single word transfer; garbage data is driven while stalled
    task automatic xfer(input logic sel3, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rdata, output int waits,
                        output logic [1:0] resp_first, output logic [1:0] resp);
        logic rdy;
        @(negedge HCLK);
        on3 = sel3; hsel0 = !sel3; hsel3 = sel3;
        haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr; hsize = HSIZE_WORD;
        @(negedge HCLK);
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = HTRANS_IDLE;
        waits = 0; rdy = 1'b0; rdata = '0; resp = '0;
        resp_first = sel3 ? rs3 : rs0;
        for (int i = 0; i < 20; i++) begin
            if ((sel3 ? ro3 : ro0) == 1'b1) begin
                rdy = 1'b1;
                hwdata = wd; wstrb = st;
                rdata = sel3 ? rd3 : rd0;
                resp = sel3 ? rs3 : rs0;
                break;
            end
            hwdata = ~wd; wstrb = 4'hF;
            waits++;
            @(negedge HCLK);
        end
        if (!rdy) check("xfer_timeout", 32'(rdy), 32'd1);
    endtask

    logic [31:0] rdata;
    logic [1:0]  rf, rs;
    int          waits;
    logic [31:0] bd [4] = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 32'h5555AAAA};

    initial begin
        bus_idle();
        on3 = 1'b0;
        repeat (2) @(negedge HCLK);
        check("rst_rdy0", 32'(ro0), 32'd1);
        check("rst_resp0", 32'(rs0), 32'd0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_rdy3", 32'(ro3), 32'd1);
        HRESET = 1'b1;

        xfer(1'b0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, rdata, waits, rf, rs);
        check("t1_wr_waits", 32'(waits), 32'd0);
        check("t1_wr_resp", 32'(rs), 32'd0);
        xfer(1'b0, 32'h1000, 1'b0, 32'h0, 4'h0, rdata, waits, rf, rs);
        check("t1_rd_waits", 32'(waits), 32'd0);
        check("t1_rd_data", rdata, 32'hDEADBEEF);

        @(negedge HCLK);
        hsel0 = 1'b1; on3 = 1'b0; haddr = 32'h0; htrans = HTRANS_BUSY; hwrite = 1'b0;
        @(negedge HCLK);
        bus_idle();
        check("busy_rdy", 32'(ro0), 32'd1);
        check("busy_rdata", rd0, 32'h0);

        dut3.mem[8] = 8'd10; dut3.mem[9] = 8'd12;
        dut3.mem[10] = 8'd14; dut3.mem[11] = 8'd16;
        xfer(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, rdata, waits, rf, rs);
        check("t2_waits", 32'(waits), 32'd3);
        check("t2_data", rdata, 32'h100E0C0A);
        check("t2_resp", 32'(rs), 32'd0);
        check("t2_resp_wait", 32'(rf), 32'd0);

        xfer(1'b1, 32'h4, 1'b1, 32'h11223344, 4'hF, rdata, waits, rf, rs);
        xfer(1'b1, 32'h4, 1'b1, 32'hAABBCCDD, 4'b0100, rdata, waits, rf, rs);
        @(negedge HCLK);
        check("t3_b4", 32'(dut3.mem[4]), 32'h44);
        check("t3_b5", 32'(dut3.mem[5]), 32'h33);
        check("t3_b6", 32'(dut3.mem[6]), 32'hBB);
        check("t3_b7", 32'(dut3.mem[7]), 32'h11);
        xfer(1'b1, 32'h4, 1'b0, 32'h0, 4'h0, rdata, waits, rf, rs);
        check("t3_rd", rdata, 32'h11BB3344);

        @(negedge HCLK);
        on3 = 1'b0; hsel0 = 1'b1; hwrite = 1'b1; hsize = HSIZE_WORD;
        haddr = 32'h0; htrans = HTRANS_NONSEQ;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("t4_wr_rdy", 32'(ro0), 32'd1);
            hwdata = bd[i]; wstrb = 4'hF;
            if (i < 3) begin
                haddr = 32'(4 * (i + 1)); htrans = HTRANS_SEQ;
            end else begin
                hsel0 = 1'b0; htrans = HTRANS_IDLE;
            end
        end
        @(negedge HCLK);
        hsel0 = 1'b1; hwrite = 1'b0; haddr = 32'h0; htrans = HTRANS_NONSEQ;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("t4_rd_rdy", 32'(ro0), 32'd1);
            check("t4_rd_data", rd0, bd[i]);
            if (i < 3) begin
                haddr = 32'(4 * (i + 1)); htrans = HTRANS_SEQ;
            end else begin
                hsel0 = 1'b0; htrans = HTRANS_IDLE;
            end
        end

        xfer(1'b0, 32'h100, 1'b1, 32'hCAFEF00D, 4'hF, rdata, waits, rf, rs);
        @(negedge HCLK);
`ifdef AHB_SLAVE_ERR_EN
        check("t5_oob_waits", 32'(waits), 32'd1);
        check("t5_oob_resp1", 32'(rf), 32'd1);
        check("t5_oob_resp2", 32'(rs), 32'd1);
        check("t5_oob_mem", mw0(0), bd[0]);
`else
        check("t5_wrap_resp", 32'(rs), 32'd0);
        check("t5_wrap_mem", mw0(0), 32'hCAFEF00D);
`endif
        xfer(1'b0, 32'h3, 1'b0, 32'h0, 4'h0, rdata, waits, rf, rs);
`ifdef AHB_SLAVE_ERR_EN
        check("t5_mis_waits", 32'(waits), 32'd1);
        check("t5_mis_resp1", 32'(rf), 32'd1);
        check("t5_mis_resp2", 32'(rs), 32'd1);
        check("t5_mis_data", rdata, 32'h0);
`else
        check("t5_mis_resp", 32'(rs), 32'd0);
        check("t5_mis_data", rdata, 32'hCAFEF00D);
`endif

        dut3.mem[32] = 8'h5A; dut3.mem[33] = 8'h5B;
        dut3.mem[34] = 8'h5C; dut3.mem[35] = 8'h5D;
        @(negedge HCLK);
        on3 = 1'b1; hsel3 = 1'b1; hwrite = 1'b1; haddr = 32'h20; htrans = HTRANS_NONSEQ;
        @(negedge HCLK);
        hsel3 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h01020304; wstrb = 4'hF;
        check("t6_in_wait", 32'(ro3), 32'd0);
        #1 HRESET = 1'b0;
        #1;
        check("t6_rst_rdy", 32'(ro3), 32'd1);
        check("t6_rst_resp", 32'(rs3), 32'd0);
        check("t6_rst_rdata", rd3, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b1;
        repeat (4) @(negedge HCLK);
        check("t6_mem", mw3(32), 32'h5D5C5B5A);
        check("t6_idle_rdy", 32'(ro3), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
